// File: rtl/tm1638_count_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module  : tm1638_count_scheduler_if
// Brief   : Counter handshake and TM1638 pin bundle for the count scheduler.
// Revision: 1.0 - initial release
// ============================================================================
interface tm1638_count_scheduler_if;
   logic       en;
   logic [7:0] val0;
   logic [7:0] val1;
   logic       cnt_en;
   logic       busy;
   logic       frame_done;
   logic       tm_stb;
   logic       tm_clk;
   logic       tm_dio;

   modport master (
      output en, val0, val1,
      input  cnt_en, busy, frame_done, tm_stb, tm_clk, tm_dio
   );

   modport slave (
      input  en, val0, val1,
      output cnt_en, busy, frame_done, tm_stb, tm_clk, tm_dio
   );
endinterface
`default_nettype wire

// File: rtl/tm1638_count_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tm1638_count_scheduler
// Brief   : Periodic count strobe plus one TM1638 refresh frame per tick.
// Revision: 1.0 - initial release
// ============================================================================
module tm1638_count_scheduler #(
   parameter int         CLK_DIV  = 4,
   parameter int         TICK_DIV = 1000000,
   parameter logic [2:0] BRIGHT   = 3'd7
) (
   input wire logic                clk,
   input wire logic                rst_n,
   tm1638_count_scheduler_if.slave bus
);
   localparam int c_TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int c_DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_TW-1:0] c_TICK_LAST = c_TW'(TICK_DIV - 1);
   localparam logic [c_DW-1:0] c_DIV_LAST  = c_DW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_BIT_LO = 3'd2,
      S_BIT_HI = 3'd3,
      S_HOLD   = 3'd4,
      S_GAP    = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t          r_state, w_state_nx;
   logic [c_TW-1:0] r_tick;
   logic [c_DW-1:0] r_div;
   logic            r_pend;
   logic [1:0]      r_grp;
   logic [4:0]      r_byte;
   logic [2:0]      r_bit;
   logic [7:0]      r_v0, r_v1;

   logic       w_wrap, w_idle, w_trig, w_phase_end, w_last_byte;
   logic [3:0] w_addr, w_nib;
   logic [7:0] w_seg, w_byte;
   logic       w_stb, w_sclk, w_dio, w_busy, w_done;

   assign w_wrap      = bus.en && (r_tick == c_TICK_LAST);
   assign w_idle      = (r_state == S_IDLE);
   assign w_trig      = w_idle && bus.en && (w_wrap || r_pend);
   assign w_phase_end = (r_div == c_DIV_LAST);
   // Only the data group carries more than one byte: 0xC0 plus 16 data bytes.
   assign w_last_byte = (r_grp == 2'd1) ? (r_byte == 5'd16) : 1'b1;

   always_comb begin
      w_addr = r_byte[3:0] - 4'd1;
      case (w_addr[2:1])
         2'd0:    w_nib = r_v1[7:4];
         2'd1:    w_nib = r_v1[3:0];
         2'd2:    w_nib = r_v0[7:4];
         default: w_nib = r_v0[3:0];
      endcase
      case (w_nib)
         4'h0: w_seg = 8'h3F;  4'h1: w_seg = 8'h06;  4'h2: w_seg = 8'h5B;  4'h3: w_seg = 8'h4F;
         4'h4: w_seg = 8'h66;  4'h5: w_seg = 8'h6D;  4'h6: w_seg = 8'h7D;  4'h7: w_seg = 8'h07;
         4'h8: w_seg = 8'h7F;  4'h9: w_seg = 8'h6F;  4'hA: w_seg = 8'h77;  4'hB: w_seg = 8'h7C;
         4'hC: w_seg = 8'h39;  4'hD: w_seg = 8'h5E;  4'hE: w_seg = 8'h79;  default: w_seg = 8'h71;
      endcase
      w_byte = 8'h00;
      case (r_grp)
         2'd0: w_byte = 8'h40;
         2'd1: begin
            if (r_byte == 5'd0)
               w_byte = 8'hC0;
            else if (!w_addr[0] && !w_addr[3])
               w_byte = w_seg;   // even address below 8 -> digit 0..3
         end
         default: w_byte = {5'b10001, BRIGHT};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      w_stb      = 1'b1;
      w_sclk     = 1'b1;
      w_dio      = 1'b1;
      w_busy     = 1'b1;
      w_done     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (w_trig) w_state_nx = S_SETUP;
         end
         S_SETUP: begin
            w_stb = 1'b0;
            if (w_phase_end) w_state_nx = S_BIT_LO;
         end
         S_BIT_LO: begin
            w_stb  = 1'b0;
            w_sclk = 1'b0;
            w_dio  = w_byte[r_bit];
            if (w_phase_end) w_state_nx = S_BIT_HI;
         end
         S_BIT_HI: begin
            w_stb = 1'b0;
            w_dio = w_byte[r_bit];
            if (w_phase_end)
               w_state_nx = (r_bit == 3'd7 && w_last_byte) ? S_HOLD : S_BIT_LO;
         end
         S_HOLD: begin
            w_stb = 1'b0;
            if (w_phase_end) w_state_nx = S_GAP;
         end
         S_GAP: begin
            if (w_phase_end) w_state_nx = (r_grp == 2'd2) ? S_DONE : S_SETUP;
         end
         S_DONE: begin
            w_busy     = 1'b0;
            w_done     = 1'b1;
            w_state_nx = S_IDLE;
         end
         default: begin
            w_busy     = 1'b0;
            w_state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick <= '0;
         r_pend <= 1'b0;
         r_div  <= '0;
         r_grp  <= 2'd0;
         r_byte <= 5'd0;
         r_bit  <= 3'd0;
         r_v0   <= 8'h00;
         r_v1   <= 8'h00;
      end else begin
         if (bus.en)
            r_tick <= w_wrap ? '0 : r_tick + 1'b1;
         // At most one queued frame; extra wraps during a frame are dropped.
         if (w_trig)
            r_pend <= 1'b0;
         else if (w_wrap && !w_idle)
            r_pend <= 1'b1;
         if (w_trig) begin
            r_v0  <= bus.val0;
            r_v1  <= bus.val1;
            r_grp <= 2'd0;
         end
         if (w_phase_end || r_state == S_IDLE || r_state == S_DONE)
            r_div <= '0;
         else
            r_div <= r_div + 1'b1;
         if (w_phase_end) begin
            case (r_state)
               S_SETUP: begin
                  r_bit  <= 3'd0;
                  r_byte <= 5'd0;
               end
               S_BIT_HI: begin
                  r_bit <= r_bit + 3'd1;
                  if (r_bit == 3'd7) r_byte <= r_byte + 5'd1;
               end
               S_GAP:   r_grp <= r_grp + 2'd1;
               default: ;
            endcase
         end
      end
   end

   assign bus.cnt_en     = w_wrap;
   assign bus.busy       = w_busy;
   assign bus.frame_done = w_done;
   assign bus.tm_stb     = w_stb;
   assign bus.tm_clk     = w_sclk;
   assign bus.tm_dio     = w_dio;
endmodule
`default_nettype wire
